dsp_lane_mac_pipe: RTL and testbench

//  Parametrised, pipelined array of LANES signed IN_W x IN_W multipliers.

---
 rtl/dsp_lane_mac_pipe.sv | 130 +++++++++++++
 tb/tb_dsp_lane_mac_pipe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_lane_mac_pipe.sv
// Three-stage signed lane multiplier array with per-beat rescale, saturation and saturation statistics.
// Define DSP_LANE_ROUND_EN to round half-up before saturation instead of truncating.
module dsp_lane_mac_pipe #(
    parameter int LANES = 16,
    parameter int IN_W  = 8,
    parameter int OUT_W = 11,
    parameter int SH0   = 3,
    parameter int SH1   = 1,
    parameter int SH2   = 2,
    parameter int SH3   = 0,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*IN_W-1:0]    inputa,
    input  logic [LANES*IN_W-1:0]    inputb,
    input  logic [1:0]               fixpoint_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*OUT_W-1:0]   outputp,
    output logic [LANES-1:0]         out_sat,
    output logic [CNT_W-1:0]         sat_cnt,
    input  logic                     sat_clr
);
    localparam int PW = 2 * IN_W;
    localparam int EW = PW + 1;
    localparam logic signed [EW-1:0] SAT_MAX = EW'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [EW-1:0] SAT_MIN = EW'(-(2 ** (OUT_W - 1)));

    logic                    adv;
    logic                    s1_valid;
    logic [LANES*IN_W-1:0]   s1_a;
    logic [LANES*IN_W-1:0]   s1_b;
    logic [1:0]              s1_op;
    logic                    s2_valid;
    logic signed [PW-1:0]    s2_p [LANES];
    logic [1:0]              s2_op;

    logic [4:0]              sh;
    logic signed [EW-1:0]    ext;
    logic signed [EW-1:0]    shifted;
    logic [LANES*OUT_W-1:0]  res;
    logic [LANES-1:0]        sat_v;
`ifdef DSP_LANE_ROUND_EN
    logic signed [EW-1:0]    bias;
`endif

    function automatic logic [4:0] shift_sel(input logic [1:0] op);
        case (op)
            2'd0:    return 5'(SH0);
            2'd1:    return 5'(SH1);
            2'd2:    return 5'(SH2);
            default: return 5'(SH3);
        endcase
    endfunction

    // One stall signal freezes every stage, so bubbles stay where they are.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    always_comb begin
        sh      = shift_sel(s2_op);
        ext     = '0;
        shifted = '0;
        res     = '0;
        sat_v   = '0;
`ifdef DSP_LANE_ROUND_EN
        bias    = (sh == 5'd0) ? '0 : (EW'(1) <<< (sh - 5'd1));
`endif
        for (int i = 0; i < LANES; i++) begin
            ext = {s2_p[i][PW-1], s2_p[i]};
`ifdef DSP_LANE_ROUND_EN
            ext = ext + bias;
`endif
            shifted = ext >>> sh;
            if (shifted > SAT_MAX) begin
                res[i*OUT_W +: OUT_W] = SAT_MAX[OUT_W-1:0];
                sat_v[i]              = 1'b1;
            end else if (shifted < SAT_MIN) begin
                res[i*OUT_W +: OUT_W] = SAT_MIN[OUT_W-1:0];
                sat_v[i]              = 1'b1;
            end else begin
                res[i*OUT_W +: OUT_W] = shifted[OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_op     <= '0;
            s2_valid  <= 1'b0;
            s2_op     <= '0;
            for (int i = 0; i < LANES; i++) begin
                s2_p[i] <= '0;
            end
            out_valid <= 1'b0;
            outputp   <= '0;
            out_sat   <= '0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s1_a      <= inputa;
            s1_b      <= inputb;
            s1_op     <= fixpoint_op;
            s2_valid  <= s1_valid;
            s2_op     <= s1_op;
            for (int i = 0; i < LANES; i++) begin
                s2_p[i] <= PW'($signed(s1_a[i*IN_W +: IN_W])) * PW'($signed(s1_b[i*IN_W +: IN_W]));
            end
            out_valid <= s2_valid;
            outputp   <= s2_valid ? res : '0;
            out_sat   <= s2_valid ? sat_v : '0;
        end
    end

    // Counts saturated result beats; sticks at all-ones, and a clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (sat_clr) begin
            sat_cnt <= '0;
        end else if (adv && s2_valid && (|sat_v) && (sat_cnt != '1)) begin
            sat_cnt <= sat_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_dsp_lane_mac_pipe.sv
// Directed scoreboard bench for dsp_lane_mac_pipe; the saturation counter is narrowed so its ceiling is reachable.
module tb_dsp_lane_mac_pipe;
    localparam int LANES = 16;
    localparam int IN_W  = 8;
    localparam int OUT_W = 11;
    localparam int CNT_W = 4;
    localparam int AW    = LANES * IN_W;
    localparam int OW    = LANES * OUT_W;

    typedef struct packed {
        logic [OW-1:0]    p;
        logic [LANES-1:0] sat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [AW-1:0]    inputa;
    logic [AW-1:0]    inputb;
    logic [1:0]       fixpoint_op;
    logic             out_valid;
    logic             out_ready;
    logic [OW-1:0]    outputp;
    logic [LANES-1:0] out_sat;
    logic [CNT_W-1:0] sat_cnt;
    logic             sat_clr;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    dsp_lane_mac_pipe #(.LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .inputa(inputa), .inputb(inputb), .fixpoint_op(fixpoint_op),
        .out_valid(out_valid), .out_ready(out_ready), .outputp(outputp),
        .out_sat(out_sat), .sat_cnt(sat_cnt), .sat_clr(sat_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_wide(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer product, optional half-up bias, floor shift, clamp to the output range.
    function automatic exp_t model(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [1:0] op);
        exp_t e;
        int   sh, p, r;
        e = '0;
        case (op)
            2'd0:    sh = 3;
            2'd1:    sh = 1;
            2'd2:    sh = 2;
            default: sh = 0;
        endcase
        for (int i = 0; i < LANES; i++) begin
            p = int'($signed(a[i*IN_W +: IN_W])) * int'($signed(b[i*IN_W +: IN_W]));
`ifdef DSP_LANE_ROUND_EN
            if (sh > 0) p = p + (1 << (sh - 1));
`endif
            r = p >>> sh;
            if (r > 1023) begin
                r = 1023;
                e.sat[i] = 1'b1;
            end else if (r < -1024) begin
                r = -1024;
                e.sat[i] = 1'b1;
            end
            e.p[i*OUT_W +: OUT_W] = r[OUT_W-1:0];
        end
        return e;
    endfunction

    function automatic logic [AW-1:0] rep(input int v);
        logic [IN_W-1:0] t;
        t = v[IN_W-1:0];
        return {LANES{t}};
    endfunction

    function automatic logic [AW-1:0] vec0(input int v);
        logic [AW-1:0] r;
        r = '0;
        r[IN_W-1:0] = v[IN_W-1:0];
        return r;
    endfunction

    function automatic logic [AW-1:0] rnd_vec();
        logic [AW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*IN_W +: IN_W] = IN_W'($urandom);
        return r;
    endfunction

    function automatic int lane0();
        return int'($signed(outputp[OUT_W-1:0]));
    endfunction

    task automatic checkOutput();
        exp_t e;
        if (out_valid && out_ready) begin
            check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_wide("sb_outputp", outputp, e.p);
                check("sb_out_sat", 32'(out_sat), 32'(e.sat));
            end
        end
        if (!out_valid) check("sat_when_idle", 32'(out_sat), 32'd0);
    endtask

    task automatic applyStimulus(input logic v, input logic [AW-1:0] a, input logic [AW-1:0] b,
                                 input logic [1:0] op, input logic rdy, input logic clr, output bit acc);
        in_valid    = v;
        inputa      = a;
        inputb      = b;
        fixpoint_op = op;
        out_ready   = rdy;
        sat_clr     = clr;
        #1;
        checkOutput();
        acc = v && in_ready;
        if (acc) sb.push_back(model(a, b, op));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic clr);
        bit acc;
        applyStimulus(1'b0, '0, '0, 2'd0, 1'b1, clr, acc);
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 10) begin
            idle(1'b0);
            lat++;
        end
    endtask

    initial begin
        bit            acc;
        int            lat;
        int            sent;
        int            t3_exp[4];
        logic [AW-1:0] ra, rb;
        logic [1:0]    rop;
        logic [OW-1:0] held;

        rst_n = 1'b0; in_valid = 1'b0; inputa = '0; inputb = '0;
        fixpoint_op = '0; out_ready = 1'b1; sat_clr = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check_wide("rst_outputp", outputp, '0);
        check("rst_out_sat", 32'(out_sat), 32'd0);
        check("rst_sat_cnt", 32'(sat_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] basic products and latency");
        applyStimulus(1'b1, vec0(5), vec0(7), 2'd0, 1'b1, 1'b0, acc);
        wait_out(lat);
        check("t1_latency", lat, 3);
        check("t1_pos_lane0", lane0(), 4);
        applyStimulus(1'b1, vec0(5), vec0(-7), 2'd0, 1'b1, 1'b0, acc);
        wait_out(lat);
`ifdef DSP_LANE_ROUND_EN
        check("t1_neg_lane0", lane0(), -4);
`else
        check("t1_neg_lane0", lane0(), -5);
`endif

        $display("[TB] saturation");
        applyStimulus(1'b1, rep(-128), rep(-128), 2'd0, 1'b1, 1'b0, acc);
        wait_out(lat);
        check_wide("t2_pos_sat", outputp, {LANES{11'h3FF}});
        check("t2_pos_flags", 32'(out_sat), 32'hFFFF);
        check("t2_cnt1", 32'(sat_cnt), 32'd1);
        applyStimulus(1'b1, rep(-128), rep(127), 2'd0, 1'b1, 1'b0, acc);
        wait_out(lat);
        check("t2_neg_lane0", lane0(), -1024);
        check("t2_neg_flags", 32'(out_sat), 32'hFFFF);
        check("t2_cnt2", 32'(sat_cnt), 32'd2);

        $display("[TB] streaming op sequence");
`ifdef DSP_LANE_ROUND_EN
        t3_exp = '{13, 50, 25, 100};
`else
        t3_exp = '{12, 50, 25, 100};
`endif
        for (int k = 0; k <= 10; k++) begin
            if (k >= 3) begin
                check("t3_out_valid", 32'(out_valid), 32'd1);
                check("t3_lane0", lane0(), t3_exp[(k - 3) % 4]);
            end
            applyStimulus(k < 8, rep(10), rep(10), 2'(k % 4), 1'b1, 1'b0, acc);
            if (k < 8) check("t3_accept", 32'(acc), 32'd1);
        end

        $display("[TB] backpressure");
        sent = 0;
        ra = rnd_vec(); rb = rnd_vec(); rop = 2'($urandom);
        held = '0;
        for (int c = 0; c < 16; c++) begin
            if (c == 4) begin
                check("t4_stall_valid", 32'(out_valid), 32'd1);
                held = outputp;
            end
            if (c > 4 && c <= 9) check_wide("t4_stable", outputp, held);
            applyStimulus(sent < 10, ra, rb, rop, !(c >= 4 && c < 9), 1'b0, acc);
            if (c >= 4 && c < 9) check("t4_no_accept", 32'(acc), 32'd0);
            if (acc) begin
                sent++;
                ra = rnd_vec(); rb = rnd_vec(); rop = 2'($urandom);
            end
        end
        check("t4_sent", sent, 10);
        for (int c = 0; c < 5; c++) idle(1'b0);
        check("t4_drained", sb.size(), 0);

        $display("[TB] saturation counter ceiling and clear");
        idle(1'b1);
        check("t5_clr", 32'(sat_cnt), 32'd0);
        for (int c = 0; c < 14; c++) applyStimulus(1'b1, rep(-128), rep(-128), 2'd0, 1'b1, 1'b0, acc);
        for (int c = 0; c < 4; c++) idle(1'b0);
        check("t5_cnt14", 32'(sat_cnt), 32'd14);
        for (int c = 0; c < 3; c++) applyStimulus(1'b1, rep(-128), rep(-128), 2'd0, 1'b1, 1'b0, acc);
        for (int c = 0; c < 4; c++) idle(1'b0);
        check("t5_hold_max", 32'(sat_cnt), 32'd15);
        applyStimulus(1'b1, rep(-128), rep(-128), 2'd0, 1'b1, 1'b0, acc);
        idle(1'b0);
        idle(1'b1);
        check("t5_clr_out_valid", 32'(out_valid), 32'd1);
        check("t5_clr_flags", 32'(out_sat), 32'hFFFF);
        check("t5_clr_wins", 32'(sat_cnt), 32'd0);
        idle(1'b0);

        $display("[TB] reset with beats in flight");
        applyStimulus(1'b1, rnd_vec(), rnd_vec(), 2'd1, 1'b1, 1'b0, acc);
        applyStimulus(1'b1, rnd_vec(), rnd_vec(), 2'd2, 1'b1, 1'b0, acc);
        idle(1'b0);
        check("t6_pre_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check_wide("t6_rst_outputp", outputp, '0);
        check("t6_rst_sat", 32'(out_sat), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            idle(1'b0);
            check("t6_flushed", 32'(out_valid), 32'd0);
        end
        applyStimulus(1'b1, rep(3), rep(-9), 2'd3, 1'b1, 1'b0, acc);
        wait_out(lat);
        check("t6_latency", lat, 3);
        for (int c = 0; c < 4; c++) idle(1'b0);
        check("final_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
